router_pkt_source: RTL and testbench

ROUTER_PKT_SOURCE -- requirements
Module: router_pkt_source

---
 rtl/router_pkt_source_if.sv | 31 +++
 rtl/router_pkt_source.sv | 187 ++++++++++++++++++
 tb/tb_router_pkt_source.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/router_pkt_source_if.sv
// Packet source bus bundle.
//   command : cmd_valid, cmd_ready, cmd_addr[1:0], cmd_len[5:0], cmd_err
//   payload : pay_valid, pay_ready, pay_data[7:0]
//   router  : busy, pkt_valid, data_out[7:0], pkt_done, pkt_count[7:0]
// master = the agent issuing commands/payload and modelling the router,
// slave  = router_pkt_source.
interface router_pkt_source_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_addr;
   logic [5:0] cmd_len;
   logic       cmd_err;
   logic       pay_valid;
   logic       pay_ready;
   logic [7:0] pay_data;
   logic       busy;
   logic       pkt_valid;
   logic [7:0] data_out;
   logic       pkt_done;
   logic [7:0] pkt_count;

   modport master (
      output cmd_valid, cmd_addr, cmd_len, pay_valid, pay_data, busy,
      input  cmd_ready, cmd_err, pay_ready, pkt_valid, data_out, pkt_done, pkt_count
   );

   modport slave (
      input  cmd_valid, cmd_addr, cmd_len, pay_valid, pay_data, busy,
      output cmd_ready, cmd_err, pay_ready, pkt_valid, data_out, pkt_done, pkt_count
   );
endinterface

// File: rtl/router_pkt_source.sv
// Router packet source: accepts a command (destination, length), buffers the
// payload bytes, then streams header, payload and parity bytes to the router
// under busy backpressure, followed by a one-cycle gap.
// Ports:
//   clk   - single clock, rising edge
//   reset - synchronous, active-high
//   bus   - router_pkt_source_if.slave (command, payload and router sides)
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | cmd_ready high, waiting for a command
// ST_FILL    | pay_ready high, collecting len payload bytes into buffer
// ST_HEADER  | header {len,addr} on data_out, pkt_valid high
// ST_PAYLOAD | buffer[idx] on data_out, pkt_valid high
// ST_PARITY  | parity byte on data_out, pkt_valid low
// ST_GAP     | one idle cycle between packets, cmd_ready low
module router_pkt_source (
   input  logic               clk,
   input  logic               reset,
   router_pkt_source_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_HEADER,
      ST_PAYLOAD,
      ST_PARITY,
      ST_GAP
   } state_t;

   state_t     state;
   state_t     state_nxt;

   logic [1:0] addr_q;
   logic [5:0] len_q;
   logic [5:0] idx;
   logic [7:0] parity;
   logic       cmd_err_q;
   logic       pkt_done_q;
   logic [7:0] pkt_count_q;
   logic [7:0] pay_buf [64];

   logic       cmd_ready_int;
   logic       cmd_fire;
   logic       cmd_good;
   logic       pay_fire;
   logic       last_idx;
   logic       accept;

   // cmd_ready is forced low while reset is held so no command can slip in
   // on the same edge that is clearing the block.
   assign cmd_ready_int = (state == ST_IDLE) && !reset;
   assign cmd_fire      = bus.cmd_valid && cmd_ready_int;
   assign cmd_good      = cmd_fire && (bus.cmd_addr != 2'd3);
   assign pay_fire      = bus.pay_valid && (state == ST_FILL);
   assign last_idx      = (idx == (len_q - 6'd1));
   assign accept        = !bus.busy;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (cmd_good) begin
               state_nxt = (bus.cmd_len == 6'd0) ? ST_HEADER : ST_FILL;
            end
         end
         ST_FILL: begin
            if (pay_fire && last_idx) begin
               state_nxt = ST_HEADER;
            end
         end
         ST_HEADER: begin
            if (accept) begin
               state_nxt = (len_q == 6'd0) ? ST_PARITY : ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            if (accept && last_idx) begin
               state_nxt = ST_PARITY;
            end
         end
         ST_PARITY: begin
            if (accept) begin
               state_nxt = ST_GAP;
            end
         end
         ST_GAP: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q      <= 2'd0;
         len_q       <= 6'd0;
         idx         <= 6'd0;
         parity      <= 8'd0;
         cmd_err_q   <= 1'b0;
         pkt_done_q  <= 1'b0;
         pkt_count_q <= 8'd0;
      end else begin
         cmd_err_q  <= cmd_fire && (bus.cmd_addr == 2'd3);
         pkt_done_q <= (state == ST_PARITY) && accept;
         case (state)
            ST_IDLE: begin
               if (cmd_good) begin
                  addr_q <= bus.cmd_addr;
                  len_q  <= bus.cmd_len;
                  idx    <= 6'd0;
                  parity <= {bus.cmd_len, bus.cmd_addr};
               end
            end
            ST_FILL: begin
               if (pay_fire) begin
                  parity <= parity ^ bus.pay_data;
                  idx    <= last_idx ? 6'd0 : idx + 6'd1;
               end
            end
            ST_HEADER: begin
               if (accept) begin
                  idx <= 6'd0;
               end
            end
            ST_PAYLOAD: begin
               if (accept) begin
                  idx <= idx + 6'd1;
               end
            end
            ST_PARITY: begin
               if (accept) begin
                  pkt_count_q <= pkt_count_q + 8'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Payload storage is deliberately not reset; a discarded packet just
   // leaves stale bytes that the next FILL overwrites.
   always_ff @(posedge clk) begin
      if (pay_fire && !reset) begin
         pay_buf[idx] <= bus.pay_data;
      end
   end

   always_comb begin
      bus.pkt_valid = 1'b0;
      bus.data_out  = 8'd0;
      case (state)
         ST_HEADER: begin
            bus.pkt_valid = 1'b1;
            bus.data_out  = {len_q, addr_q};
         end
         ST_PAYLOAD: begin
            bus.pkt_valid = 1'b1;
            bus.data_out  = pay_buf[idx];
         end
         ST_PARITY: begin
            bus.data_out  = parity;
         end
         default: begin
         end
      endcase
   end

   assign bus.cmd_ready = cmd_ready_int;
   assign bus.pay_ready = (state == ST_FILL);
   assign bus.cmd_err   = cmd_err_q;
   assign bus.pkt_done  = pkt_done_q;
   assign bus.pkt_count = pkt_count_q;

endmodule

// File: tb/tb_router_pkt_source.sv
// Bench for router_pkt_source: directed packets plus randomized traffic,
// compared against a byte-sequence model of each packet.
module tb_router_pkt_source;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   router_pkt_source_if bus ();

   router_pkt_source dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int         n_tests = 0;
   int         n_fail  = 0;
   int         model_count = 0;
   int         span;
   logic [7:0] pl [64];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic drive_idle;
      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = 2'd0;
      bus.cmd_len   = 6'd0;
      bus.pay_valid = 1'b0;
      bus.pay_data  = 8'd0;
      bus.busy      = 1'b0;
   endtask

   // mode 0: busy always low, 1: random busy and payload gaps,
   // 2: busy 3 cycles on header and 2 cycles on second payload byte.
   // Called at a negedge with the DUT idle; returns at a negedge with it idle.
   task automatic send_packet(input logic [1:0] addr, input logic [5:0] len,
                              input int mode, output int cycles);
      logic [7:0] exp_b [$];
      logic [7:0] par;
      int         i;
      int         held;
      int         guard;
      int         n_bytes;

      par = {len, addr};
      exp_b.push_back(par);
      for (int k = 0; k < int'(len); k++) begin
         exp_b.push_back(pl[k]);
         par = par ^ pl[k];
      end
      exp_b.push_back(par);
      n_bytes = exp_b.size();

      check_eq("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_addr  = addr;
      bus.cmd_len   = len;
      if (mode == 1) bus.busy = 1'($urandom_range(0, 1));
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = 2'($urandom_range(0, 3));
      bus.cmd_len   = 6'($urandom_range(0, 63));

      for (int k = 0; k < int'(len); k++) begin
         guard = 0;
         while (mode == 1 && $urandom_range(0, 2) == 0 && guard < 8) begin
            bus.pay_valid = 1'b0;
            bus.pay_data  = 8'($urandom);
            bus.busy      = 1'($urandom_range(0, 1));
            check_eq("pkt_valid_fill", 32'(bus.pkt_valid), 32'd0);
            @(negedge clk);
            guard++;
         end
         check_eq("pay_ready_fill", 32'(bus.pay_ready), 32'd1);
         bus.pay_valid = 1'b1;
         bus.pay_data  = pl[k];
         @(negedge clk);
         bus.pay_valid = 1'b0;
      end

      cycles = 0;
      i      = 0;
      held   = 0;
      guard  = 0;
      while (i < n_bytes && guard < 400) begin
         check_eq("data_out", 32'(bus.data_out), 32'(exp_b[i]));
         check_eq("pkt_valid", 32'(bus.pkt_valid), (i < n_bytes - 1) ? 32'd1 : 32'd0);
         case (mode)
            1:       bus.busy = 1'($urandom_range(0, 1));
            2:       bus.busy = ((i == 0 && held < 3) || (i == 2 && held < 2)) ? 1'b1 : 1'b0;
            default: bus.busy = 1'b0;
         endcase
         @(negedge clk);
         cycles++;
         guard++;
         if (!bus.busy) begin
            i++;
            held = 0;
         end else begin
            held++;
         end
      end
      check_eq("bytes_accepted", 32'(i), 32'(n_bytes));
      bus.busy = 1'b0;

      model_count++;
      check_eq("pkt_done_pulse", 32'(bus.pkt_done), 32'd1);
      check_eq("gap_pkt_valid", 32'(bus.pkt_valid), 32'd0);
      check_eq("gap_data_out", 32'(bus.data_out), 32'd0);
      check_eq("gap_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      check_eq("pkt_count", 32'(bus.pkt_count), 32'(model_count & 255));
      @(negedge clk);
      check_eq("pkt_done_clear", 32'(bus.pkt_done), 32'd0);
      check_eq("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
   endtask

   task automatic send_bad_cmd;
      check_eq("bad_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_addr  = 2'd3;
      bus.cmd_len   = 6'd5;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      check_eq("cmd_err_pulse", 32'(bus.cmd_err), 32'd1);
      check_eq("bad_pay_ready", 32'(bus.pay_ready), 32'd0);
      check_eq("bad_stay_idle", 32'(bus.cmd_ready), 32'd1);
      @(negedge clk);
      check_eq("cmd_err_clear", 32'(bus.cmd_err), 32'd0);
      check_eq("bad_pkt_valid", 32'(bus.pkt_valid), 32'd0);
      check_eq("bad_pay_ready2", 32'(bus.pay_ready), 32'd0);
      check_eq("bad_pkt_count", 32'(bus.pkt_count), 32'(model_count & 255));
   endtask

   initial begin
      drive_idle();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      check_eq("rst_pkt_valid", 32'(bus.pkt_valid), 32'd0);
      check_eq("rst_data_out", 32'(bus.data_out), 32'd0);
      check_eq("rst_cmd_err", 32'(bus.cmd_err), 32'd0);
      check_eq("rst_pkt_done", 32'(bus.pkt_done), 32'd0);
      check_eq("rst_pkt_count", 32'(bus.pkt_count), 32'd0);
      check_eq("rst_pay_ready", 32'(bus.pay_ready), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check_eq("post_rst_ready", 32'(bus.cmd_ready), 32'd1);

      // Reset in the middle of the payload, while byte index 2 is shown.
      for (int k = 0; k < 5; k++) pl[k] = 8'hA0 + 8'(k);
      bus.cmd_valid = 1'b1;
      bus.cmd_addr  = 2'd0;
      bus.cmd_len   = 6'd5;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         bus.pay_valid = 1'b1;
         bus.pay_data  = pl[k];
         @(negedge clk);
      end
      bus.pay_valid = 1'b0;
      check_eq("mid_header", 32'(bus.data_out), 32'h14);
      repeat (3) @(negedge clk);
      check_eq("mid_payload2", 32'(bus.data_out), 32'(pl[2]));
      reset = 1'b1;
      @(negedge clk);
      check_eq("mid_rst_pv", 32'(bus.pkt_valid), 32'd0);
      check_eq("mid_rst_data", 32'(bus.data_out), 32'd0);
      check_eq("mid_rst_ready", 32'(bus.cmd_ready), 32'd0);
      check_eq("mid_rst_done", 32'(bus.pkt_done), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check_eq("mid_rel_ready", 32'(bus.cmd_ready), 32'd1);
      check_eq("mid_rel_done", 32'(bus.pkt_done), 32'd0);
      check_eq("mid_rel_count", 32'(bus.pkt_count), 32'd0);
      check_eq("mid_rel_pv", 32'(bus.pkt_valid), 32'd0);
      model_count = 0;

      // addr 1, len 3, no backpressure: five bytes, five cycles
      pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
      send_packet(2'd1, 6'd3, 0, span);
      check_eq("span_nobusy", 32'(span), 32'd5);

      // same packet with 3+2 busy cycles
      send_packet(2'd1, 6'd3, 2, span);
      check_eq("span_busy", 32'(span), 32'd10);

      // empty payload
      send_packet(2'd2, 6'd0, 0, span);
      check_eq("span_len0", 32'(span), 32'd2);

      send_bad_cmd();

      // full-length packet with random gaps and backpressure
      for (int k = 0; k < 63; k++) pl[k] = 8'(k);
      send_packet(2'd0, 6'd63, 1, span);

      // random traffic until the packet counter has wrapped
      while (model_count < 256) begin
         for (int k = 0; k < 64; k++) pl[k] = 8'($urandom);
         if ($urandom_range(0, 15) == 0) send_bad_cmd();
         send_packet(2'($urandom_range(0, 2)), 6'($urandom_range(0, 63)),
                     int'($urandom_range(0, 1)), span);
      end
      check_eq("pkt_count_wrap", 32'(bus.pkt_count), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
